rv32m_div_sequencer: RTL

- Iterative execution unit for RV32M DIV, DIVU, REM and REMU.
- Sits behind the divide reservation station in the OoO core: accepts one issued operation at a time and sequences a shared radix-2 restoring divider for 32 cycles.
- Special cases (divide-by-zero, signed overflow) resolve with short latency.
- The tagged result goes out through a valid/ready handshake to the CDB arbiter.

---
 rtl/rv32m_div_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/rv32m_div_sequencer.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring radix-2 divider, one quotient bit per cycle,
// with short-latency divide-by-zero and signed-overflow results and a tagged valid/ready response.
module rv32m_div_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_nx;
    logic [XLEN-1:0]    rem_q, quo_q, dvs_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_rem_q, q_neg_q, r_neg_q;

    logic               accept_c, signed_c, div0_c, ovf_c, last_c, ge_c;
    logic [XLEN-1:0]    rs1_mag_c, rs2_mag_c, special_c;
    logic [XLEN:0]      shifted_c;
    logic [XLEN-1:0]    rem_nx_c, quo_nx_c, q_fix_c, r_fix_c, final_c;

    assign req_ready  = (state_q == IDLE) & ~reset & ~flush;
    assign resp_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);

    // Request decode: magnitudes and special-case results
    always_comb begin
        accept_c  = req_valid & req_ready;
        signed_c  = ~req_op[0];
        div0_c    = (req_rs2 == '0);
        ovf_c     = signed_c & (req_rs1 == INT_MIN) & (req_rs2 == '1);
        rs1_mag_c = (signed_c & req_rs1[XLEN-1]) ? (XLEN'(0) - req_rs1) : req_rs1;
        rs2_mag_c = (signed_c & req_rs2[XLEN-1]) ? (XLEN'(0) - req_rs2) : req_rs2;
        if (div0_c) special_c = req_op[1] ? req_rs1 : '1;
        else        special_c = req_op[1] ? '0 : INT_MIN;
    end

    // One restoring step plus sign correction of the final step's result
    always_comb begin
        shifted_c = {rem_q, quo_q[XLEN-1]};
        ge_c      = (shifted_c >= {1'b0, dvs_q});
        rem_nx_c  = ge_c ? (shifted_c[XLEN-1:0] - dvs_q) : shifted_c[XLEN-1:0];
        quo_nx_c  = {quo_q[XLEN-2:0], ge_c};
        q_fix_c   = q_neg_q ? (XLEN'(0) - quo_nx_c) : quo_nx_c;
        r_fix_c   = r_neg_q ? (XLEN'(0) - rem_nx_c) : rem_nx_c;
        final_c   = is_rem_q ? r_fix_c : q_fix_c;
        last_c    = (cnt_q == CNT_W'(XLEN-1));
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept_c) state_nx = (div0_c | ovf_c) ? DONE : CALC;
                CALC:    if (last_c) state_nx = DONE;
                DONE:    if (resp_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            is_rem_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            resp_data <= '0;
            resp_tag  <= '0;
        end else if (accept_c) begin
            resp_tag <= req_tag;
            is_rem_q <= req_op[1];
            q_neg_q  <= signed_c & (req_rs1[XLEN-1] ^ req_rs2[XLEN-1]);
            r_neg_q  <= signed_c & req_rs1[XLEN-1];
            cnt_q    <= '0;
            if (div0_c | ovf_c) begin
                resp_data <= special_c;
            end else begin
                rem_q <= '0;
                quo_q <= rs1_mag_c;
                dvs_q <= rs2_mag_c;
            end
        end else if ((state_q == CALC) && !flush) begin
            rem_q <= rem_nx_c;
            quo_q <= quo_nx_c;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) resp_data <= final_c;
        end
    end

endmodule
